// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the memory stage.
package pipe_pkg;

  typedef enum logic {IDLE, BUSY} mem_state_t;

  localparam int unsigned WORD_ALIGN_BITS = 2;
  localparam int unsigned REG_ADDR_W      = 4;

  // Copy of the EX/MEM control fields held while an access is outstanding.
  typedef struct packed {
    logic                  PCSrc;
    logic                  RegWrite;
    logic                  MemtoReg;
    logic                  MemWrite;
    logic [REG_ADDR_W-1:0] WA3;
  } mem_ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles without DAck; expired flags the last cycle before abort.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LastCnt);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: issues loads/stores over a req/ack bus and drives the MEM/WB register.
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned BITS    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [BITS-1:0]       ALUResultM,
  input  logic [BITS-1:0]       WriteDataM,
  input  logic                  PCSrcM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [REG_ADDR_W-1:0] WA3M,
  output logic                  DReq,
  output logic                  DWe,
  output logic [BITS-1:0]       DAddr,
  output logic [BITS-1:0]       DWData,
  input  logic [BITS-1:0]       DRData,
  input  logic                  DAck,
  output logic [BITS-1:0]       ALUOutW,
  output logic [BITS-1:0]       ReadDataW,
  output logic                  PCSrcW,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [REG_ADDR_W-1:0] WA3W,
  output logic                  StallM,
  output logic                  BusErr
);

  mem_state_t            state_q, state_d;
  mem_ctrl_t             lat_q, lat_d;
  logic                  dreq_q, dreq_d, dwe_q, dwe_d;
  logic [BITS-1:0]       daddr_q, daddr_d, dwdata_q, dwdata_d;
  logic [BITS-1:0]       alu_out_q, alu_out_d, rdata_q, rdata_d;
  logic                  pcsrc_q, pcsrc_d, regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
  logic [REG_ADDR_W-1:0] wa3_q, wa3_d;
  logic                  bus_err_q, bus_err_d;

  logic mem_op, misaligned, expired, timer_clr, timer_en;

  assign mem_op     = MemtoRegM | MemWriteM;
  assign misaligned = |ALUResultM[WORD_ALIGN_BITS-1:0];
  assign timer_en   = (state_q == BUSY) & ~DAck & ~expired;
  assign timer_clr  = (state_q != BUSY) | DAck | expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    dreq_d     = dreq_q;
    dwe_d      = dwe_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    alu_out_d  = alu_out_q;
    rdata_d    = rdata_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    wa3_d      = wa3_q;
    bus_err_d  = bus_err_q;
    StallM     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          alu_out_d  = ALUResultM;
          pcsrc_d    = PCSrcM;
          regwrite_d = RegWriteM;
          memtoreg_d = MemtoRegM;
          wa3_d      = WA3M;
        end else begin
          // Both misaligned and issued ops send a bubble (write-enables only).
          pcsrc_d    = 1'b0;
          regwrite_d = 1'b0;
          memtoreg_d = 1'b0;
          if (misaligned) begin
            bus_err_d = 1'b1;
          end else begin
            StallM   = 1'b1;
            state_d  = BUSY;
            dreq_d   = 1'b1;
            dwe_d    = MemWriteM;
            daddr_d  = ALUResultM;
            dwdata_d = WriteDataM;
            lat_d    = '{PCSrc: PCSrcM, RegWrite: RegWriteM, MemtoReg: MemtoRegM,
                         MemWrite: MemWriteM, WA3: WA3M};
          end
        end
      end
      BUSY: begin
        if (DAck) begin
          state_d    = IDLE;
          dreq_d     = 1'b0;
          alu_out_d  = daddr_q;
          pcsrc_d    = lat_q.PCSrc;
          regwrite_d = lat_q.RegWrite & ~lat_q.MemWrite;
          memtoreg_d = lat_q.MemtoReg;
          wa3_d      = lat_q.WA3;
          if (!lat_q.MemWrite) begin
            rdata_d = DRData;
          end
        end else begin
          pcsrc_d    = 1'b0;
          regwrite_d = 1'b0;
          memtoreg_d = 1'b0;
          if (expired) begin
            state_d   = IDLE;
            dreq_d    = 1'b0;
            bus_err_d = 1'b1;
          end else begin
            StallM = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      dreq_q     <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      alu_out_q  <= '0;
      rdata_q    <= '0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      wa3_q      <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      dreq_q     <= dreq_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      alu_out_q  <= alu_out_d;
      rdata_q    <= rdata_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      wa3_q      <= wa3_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign DReq      = dreq_q;
  assign DWe       = dwe_q;
  assign DAddr     = daddr_q;
  assign DWData    = dwdata_q;
  assign ALUOutW   = alu_out_q;
  assign ReadDataW = rdata_q;
  assign PCSrcW    = pcsrc_q;
  assign RegWriteW = regwrite_q;
  assign MemtoRegW = memtoreg_q;
  assign WA3W      = wa3_q;
  assign BusErr    = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a short timeout.
module tb_mem_stage_ctrl;

  localparam int unsigned BITS = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [BITS-1:0] ALUResultM, WriteDataM, DRData;
  logic            PCSrcM, RegWriteM, MemtoRegM, MemWriteM, DAck;
  logic [3:0]      WA3M, WA3W;
  logic            DReq, DWe, PCSrcW, RegWriteW, MemtoRegW, StallM, BusErr;
  logic [BITS-1:0] DAddr, DWData, ALUOutW, ReadDataW;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(
    .BITS    (BITS),
    .TIMEOUT (4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .WA3M       (WA3M),
    .DReq       (DReq),
    .DWe        (DWe),
    .DAddr      (DAddr),
    .DWData     (DWData),
    .DRData     (DRData),
    .DAck       (DAck),
    .ALUOutW    (ALUOutW),
    .ReadDataW  (ReadDataW),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .WA3W       (WA3W),
    .StallM     (StallM),
    .BusErr     (BusErr)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_m(input logic [BITS-1:0] alu, input logic [BITS-1:0] wd, input logic pcs,
                       input logic rw, input logic m2r, input logic mw, input logic [3:0] wa);
    ALUResultM = alu; WriteDataM = wd; PCSrcM = pcs; RegWriteM = rw;
    MemtoRegM = m2r; MemWriteM = mw; WA3M = wa;
  endtask

  task automatic set_nop;
    set_m(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reset;
    RST_N = 1'b0; DAck = 1'b0; DRData = '0;
    set_nop();
    tick(); tick();
    total_cnt++; if (DReq !== 1'b0) $display("FAIL reset_dreq got %b want 0", DReq); else pass_cnt++;
    total_cnt++;
    if ({ALUOutW, ReadDataW, PCSrcW, RegWriteW, MemtoRegW, WA3W} !== '0)
      $display("FAIL reset_w got %h/%h/%b%b%b/%h want all 0", ALUOutW, ReadDataW, PCSrcW,
               RegWriteW, MemtoRegW, WA3W);
    else pass_cnt++;
    total_cnt++; if (BusErr !== 1'b0) $display("FAIL reset_buserr got %b want 0", BusErr); else pass_cnt++;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL reset_stall got %b want 0", StallM); else pass_cnt++;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_alu_op;
    set_m(32'h0000_00AA, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    #1;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL alu_stall got %b want 0", StallM); else pass_cnt++;
    tick();
    total_cnt++; if (ALUOutW !== 32'hAA) $display("FAIL alu_out got %h want 000000aa", ALUOutW); else pass_cnt++;
    total_cnt++; if (RegWriteW !== 1'b1) $display("FAIL alu_regwrite got %b want 1", RegWriteW); else pass_cnt++;
    total_cnt++; if (WA3W !== 4'd3) $display("FAIL alu_wa3 got %h want 3", WA3W); else pass_cnt++;
    total_cnt++; if (DReq !== 1'b0) $display("FAIL alu_dreq got %b want 0", DReq); else pass_cnt++;
  endtask

  task automatic test_load_zero_wait;
    set_m(32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
    #1;
    total_cnt++; if (StallM !== 1'b1) $display("FAIL ld_stall_idle got %b want 1", StallM); else pass_cnt++;
    tick();
    total_cnt++; if (DReq !== 1'b1) $display("FAIL ld_dreq got %b want 1", DReq); else pass_cnt++;
    total_cnt++; if (DAddr !== 32'h100) $display("FAIL ld_daddr got %h want 00000100", DAddr); else pass_cnt++;
    total_cnt++; if (DWe !== 1'b0) $display("FAIL ld_dwe got %b want 0", DWe); else pass_cnt++;
    total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL ld_bubble got %b want 0", RegWriteW); else pass_cnt++;
    DAck = 1'b1; DRData = 32'hDEAD_BEEF;
    set_nop();
    #1;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL ld_stall_ack got %b want 0", StallM); else pass_cnt++;
    tick();
    DAck = 1'b0;
    total_cnt++; if (DReq !== 1'b0) $display("FAIL ld_dreq_fall got %b want 0", DReq); else pass_cnt++;
    total_cnt++;
    if (ReadDataW !== 32'hDEAD_BEEF) $display("FAIL ld_rdata got %h want deadbeef", ReadDataW);
    else pass_cnt++;
    total_cnt++;
    if ({MemtoRegW, RegWriteW, WA3W} !== {1'b1, 1'b1, 4'd5})
      $display("FAIL ld_ctrl got %b%b/%h want 11/5", MemtoRegW, RegWriteW, WA3W);
    else pass_cnt++;
    total_cnt++; if (ALUOutW !== 32'h100) $display("FAIL ld_aluout got %h want 00000100", ALUOutW); else pass_cnt++;
  endtask

  task automatic test_store_wait3;
    set_m(32'h200, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
    #1;
    total_cnt++; if (StallM !== 1'b1) $display("FAIL st_stall_idle got %b want 1", StallM); else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total_cnt++;
      if ({DReq, DWe, DWData} !== {1'b1, 1'b1, 32'h1234})
        $display("FAIL st_bus_c%0d got %b%b/%h want 11/00001234", k, DReq, DWe, DWData);
      else pass_cnt++;
      total_cnt++;
      if (RegWriteW !== 1'b0) $display("FAIL st_regwrite_c%0d got %b want 0", k, RegWriteW);
      else pass_cnt++;
      if (k < 4) begin
        total_cnt++;
        if (StallM !== 1'b1) $display("FAIL st_stall_c%0d got %b want 1", k, StallM); else pass_cnt++;
      end
    end
    // DAck on the cycle the timer would otherwise expire.
    DAck = 1'b1;
    set_nop();
    #1;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL st_stall_ack got %b want 0", StallM); else pass_cnt++;
    tick();
    DAck = 1'b0;
    total_cnt++; if (DReq !== 1'b0) $display("FAIL st_dreq_fall got %b want 0", DReq); else pass_cnt++;
    total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL st_regwrite_done got %b want 0", RegWriteW); else pass_cnt++;
    total_cnt++; if (BusErr !== 1'b0) $display("FAIL st_buserr got %b want 0", BusErr); else pass_cnt++;
  endtask

  task automatic test_load_store_both;
    set_m(32'h500, 32'hCAFE, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    tick();
    total_cnt++; if (DWe !== 1'b1) $display("FAIL both_dwe got %b want 1", DWe); else pass_cnt++;
    DAck = 1'b1; DRData = 32'hFFFF_FFFF;
    set_nop();
    tick();
    DAck = 1'b0;
    total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL both_regwrite got %b want 0", RegWriteW); else pass_cnt++;
    total_cnt++;
    if (ReadDataW !== 32'hDEAD_BEEF) $display("FAIL both_rdata got %h want deadbeef", ReadDataW);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    set_m(32'h300, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
    for (int k = 1; k <= 4; k++) begin
      tick();
      total_cnt++; if (DReq !== 1'b1) $display("FAIL to_dreq_c%0d got %b want 1", k, DReq); else pass_cnt++;
      total_cnt++;
      if (StallM !== (k < 4)) $display("FAIL to_stall_c%0d got %b want %b", k, StallM, k < 4);
      else pass_cnt++;
    end
    set_m(32'h55, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    total_cnt++; if (DReq !== 1'b0) $display("FAIL to_dreq_drop got %b want 0", DReq); else pass_cnt++;
    total_cnt++; if (BusErr !== 1'b1) $display("FAIL to_buserr got %b want 1", BusErr); else pass_cnt++;
    total_cnt++;
    if ({RegWriteW, MemtoRegW} !== 2'b00) $display("FAIL to_bubble got %b%b want 00", RegWriteW, MemtoRegW);
    else pass_cnt++;
    tick();
    set_nop();
    total_cnt++;
    if ({ALUOutW, RegWriteW, WA3W} !== {32'h55, 1'b1, 4'd2})
      $display("FAIL to_next_alu got %h/%b/%h want 00000055/1/2", ALUOutW, RegWriteW, WA3W);
    else pass_cnt++;
    total_cnt++; if (BusErr !== 1'b1) $display("FAIL to_buserr_sticky got %b want 1", BusErr); else pass_cnt++;
  endtask

  task automatic test_misaligned;
    RST_N = 1'b0;
    #3;
    RST_N = 1'b1;
    tick();
    total_cnt++; if (BusErr !== 1'b0) $display("FAIL mis_pre_buserr got %b want 0", BusErr); else pass_cnt++;
    set_m(32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    #1;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL mis_stall got %b want 0", StallM); else pass_cnt++;
    tick();
    set_nop();
    total_cnt++; if (DReq !== 1'b0) $display("FAIL mis_dreq got %b want 0", DReq); else pass_cnt++;
    total_cnt++; if (BusErr !== 1'b1) $display("FAIL mis_buserr got %b want 1", BusErr); else pass_cnt++;
    total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL mis_regwrite got %b want 0", RegWriteW); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access;
    set_m(32'h400, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8);
    tick();
    tick();
    total_cnt++; if (DReq !== 1'b1) $display("FAIL rst_pre_dreq got %b want 1", DReq); else pass_cnt++;
    set_nop();
    RST_N = 1'b0;
    #1;
    total_cnt++; if (DReq !== 1'b0) $display("FAIL rst_dreq got %b want 0", DReq); else pass_cnt++;
    total_cnt++;
    if ({ALUOutW, ReadDataW, PCSrcW, RegWriteW, MemtoRegW, WA3W, BusErr} !== '0)
      $display("FAIL rst_w got %h/%h/%b%b%b/%h/%b want all 0", ALUOutW, ReadDataW, PCSrcW,
               RegWriteW, MemtoRegW, WA3W, BusErr);
    else pass_cnt++;
    #2;
    RST_N = 1'b1;
    tick();
    DAck = 1'b1; DRData = 32'h1357_9BDF;
    #1;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL rst_stray_stall got %b want 0", StallM); else pass_cnt++;
    tick();
    DAck = 1'b0;
    total_cnt++; if (DReq !== 1'b0) $display("FAIL rst_stray_dreq got %b want 0", DReq); else pass_cnt++;
    total_cnt++; if (ReadDataW !== '0) $display("FAIL rst_stray_rdata got %h want 0", ReadDataW); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_zero_wait();
    test_store_wait3();
    test_load_store_both();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
